// File: rtl/matmul_pkg.sv
// Shared constants, state encoding and helper functions for the matmul sequencer.
package matmul_pkg;

    // Default configuration of the sequencer and its datapath.
    localparam int DATA_WIDTH_DEF = 8;
    localparam int BUS_WIDTH_DEF  = 32;
    localparam int SP_DEPTH_DEF   = 4;
    localparam int TIMEOUT_DEF    = 32;
    localparam int CNT_W_DEF      = 8;

    // Dimensions travel as dim-1, so 2 bits cover 1..4.
    localparam int DIM_W = 2;

    // Number of elements per bus word, i.e. the largest matrix dimension.
    function automatic int max_dim_f(input int bus_width, input int data_width);
        return bus_width / data_width;
    endfunction

    // Scratchpad slot address width, never narrower than one bit.
    function automatic int sp_aw_f(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // One-hot operation states.
    typedef enum logic [6:0] {
        ST_IDLE   = 7'b0000001,
        ST_LOAD   = 7'b0000010,
        ST_LAUNCH = 7'b0000100,
        ST_WAIT   = 7'b0001000,
        ST_STORE  = 7'b0010000,
        ST_DONE   = 7'b0100000,
        ST_ERR    = 7'b1000000
    } state_e;

endpackage

// File: rtl/matmul_sequencer_op_timer.sv
// Saturating cycle counter used as the WAIT-state watchdog.
module op_timer #(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o,
    output logic             tc_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] TC_VAL  = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear wins, otherwise count up and stick at all-ones.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign tc_o    = (count_q == TC_VAL);

endmodule

// File: rtl/matmul_sequencer.sv
// Control FSM running one matrix multiply on matrix_shifter: latch config,
// load operands, launch, wait for done under a watchdog, commit the result.
//
// Handshake: start_i is a request sampled only in IDLE; there is no ready,
// a request seen in any other state is dropped. shifter_done_i is honoured
// only in WAIT, so a stale done from a previous operation is harmless.
module matmul_sequencer
    import matmul_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int BUS_WIDTH  = BUS_WIDTH_DEF,
    parameter int SP_DEPTH   = SP_DEPTH_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF,
    parameter int CNT_W      = CNT_W_DEF,
    parameter int SP_AW      = sp_aw_f(SP_DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [DIM_W-1:0] n_i,
    input  logic [DIM_W-1:0] k_i,
    input  logic [DIM_W-1:0] m_i,
    input  logic             mode_i,
    input  logic [SP_AW-1:0] sp_rd_sel_i,
    input  logic [SP_AW-1:0] sp_wr_sel_i,
    input  logic             shifter_done_i,
    output logic             operand_load_o,
    output logic             shifter_start_o,
    output logic [DIM_W-1:0] n_o,
    output logic [DIM_W-1:0] k_o,
    output logic [DIM_W-1:0] m_o,
    output logic             c_src_sel_o,
    output logic [SP_AW-1:0] sp_rd_addr_o,
    output logic             sp_wr_en_o,
    output logic [SP_AW-1:0] sp_wr_addr_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             error_o,
    output logic [CNT_W-1:0] cycles_o,
    output logic [6:0]       state_dbg_o
);

    localparam int MAX_DIM = max_dim_f(BUS_WIDTH, DATA_WIDTH);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    // Reject configurations the dimension encoding or watchdog cannot cover.
    generate
        if ((MAX_DIM != (1 << DIM_W)) || (TIMEOUT <= 3 * MAX_DIM) ||
            (TIMEOUT > (1 << CNT_W) - 1) || (SP_DEPTH > (1 << SP_AW))) begin : g_bad_cfg
            $error("matmul_sequencer: unsupported parameter combination");
        end
    endgenerate

    state_e state_q;
    state_e state_d;

    logic [DIM_W-1:0] n_q, k_q, m_q;
    logic             mode_q;
    logic [SP_AW-1:0] rd_addr_q;
    logic [SP_AW-1:0] wr_addr_q;
    logic             error_q;
    logic [CNT_W-1:0] cycles_q;

    logic             start_accept;
    logic             in_wait;
    logic             wait_done;
    logic             wait_timeout;
    logic [CNT_W-1:0] wait_count;
    logic             wait_tc;

    assign start_accept = (state_q == ST_IDLE) && start_i;
    assign in_wait      = (state_q == ST_WAIT);
    assign wait_done    = in_wait && shifter_done_i;
    assign wait_timeout = in_wait && !shifter_done_i && wait_tc;

    // Watchdog counts WAIT cycles only and restarts from zero on every entry.
    op_timer #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) u_op_timer (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (!in_wait),
        .en_i    (in_wait),
        .count_o (wait_count),
        .tc_o    (wait_tc)
    );

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a done in the terminal-count cycle still counts as success.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (start_i) state_d = ST_LOAD;
            ST_LOAD:   state_d = ST_LAUNCH;
            ST_LAUNCH: state_d = ST_WAIT;
            ST_WAIT: begin
                if (shifter_done_i) begin
                    state_d = ST_STORE;
                end else if (wait_tc) begin
                    state_d = ST_ERR;
                end
            end
            ST_STORE:  state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            ST_ERR:    state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Operation config is captured on an accepted start and held until the next one.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            n_q       <= '0;
            k_q       <= '0;
            m_q       <= '0;
            mode_q    <= 1'b0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
        end else if (start_accept) begin
            n_q       <= n_i;
            k_q       <= k_i;
            m_q       <= m_i;
            mode_q    <= mode_i;
            rd_addr_q <= sp_rd_sel_i;
            wr_addr_q <= sp_wr_sel_i;
        end
    end

    // Status: sticky watchdog error and the WAIT-cycle count of the last op.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            error_q  <= 1'b0;
            cycles_q <= '0;
        end else begin
            if (start_accept) begin
                error_q <= 1'b0;
            end
            if (wait_done) begin
                cycles_q <= wait_count + CNT_W'(1);
            end else if (wait_timeout) begin
                cycles_q <= TIMEOUT_CNT;
                error_q  <= 1'b1;
            end
        end
    end

    // Strobes and mux select decoded from the current state.
    always_comb begin
        operand_load_o  = 1'b0;
        shifter_start_o = 1'b0;
        sp_wr_en_o      = 1'b0;
        done_o          = 1'b0;
        c_src_sel_o     = 1'b0;
        busy_o          = (state_q != ST_IDLE);
        unique case (state_q)
            ST_LOAD: begin
                operand_load_o = 1'b1;
                c_src_sel_o    = mode_q;
            end
            ST_LAUNCH: begin
                shifter_start_o = 1'b1;
                c_src_sel_o     = mode_q;
            end
            ST_WAIT: begin
                c_src_sel_o = mode_q;
            end
            ST_STORE: begin
                sp_wr_en_o  = 1'b1;
                c_src_sel_o = mode_q;
            end
            ST_DONE:  done_o = 1'b1;
            ST_ERR:   done_o = 1'b1;
            default: begin
                done_o = 1'b0;
            end
        endcase
    end

    assign n_o          = n_q;
    assign k_o          = k_q;
    assign m_o          = m_q;
    assign sp_rd_addr_o = rd_addr_q;
    assign sp_wr_addr_o = wr_addr_q;
    assign error_o      = error_q;
    assign cycles_o     = cycles_q;
    assign state_dbg_o  = state_q;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed bench for matmul_sequencer: a vector table of whole operations plus
// hand-written reset and lockout sequences, checked against hand-computed values.
module tb_matmul_sequencer;

    localparam int TIMEOUT = 32;
    localparam int CNT_W   = 8;
    localparam int SP_AW   = 2;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             start_i;
    logic [1:0]       n_i, k_i, m_i;
    logic             mode_i;
    logic [SP_AW-1:0] sp_rd_sel_i, sp_wr_sel_i;
    logic             shifter_done_i;
    logic             operand_load_o, shifter_start_o;
    logic [1:0]       n_o, k_o, m_o;
    logic             c_src_sel_o;
    logic [SP_AW-1:0] sp_rd_addr_o, sp_wr_addr_o;
    logic             sp_wr_en_o, busy_o, done_o, error_o;
    logic [CNT_W-1:0] cycles_o;
    logic [6:0]       state_dbg_o;

    int checks = 0;
    int errors = 0;

    logic [CNT_W-1:0] exp_q[$];

    logic [1:0]       pn, pk, pm;
    logic [SP_AW-1:0] prd, pwr;

    typedef struct {
        logic [1:0]       n, k, m;
        logic             mode;
        logic [SP_AW-1:0] rd, wr;
        int               delay;      // WAIT cycle that sees done; 0 = never
        logic             stale;      // done held high during LAUNCH
        logic             poke;       // start pulses during WAIT and DONE
        logic [CNT_W-1:0] exp_cycles;
        logic             exp_err;
    } vec_t;

    vec_t vecs[6];

    matmul_sequencer u_dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .start_i         (start_i),
        .n_i             (n_i),
        .k_i             (k_i),
        .m_i             (m_i),
        .mode_i          (mode_i),
        .sp_rd_sel_i     (sp_rd_sel_i),
        .sp_wr_sel_i     (sp_wr_sel_i),
        .shifter_done_i  (shifter_done_i),
        .operand_load_o  (operand_load_o),
        .shifter_start_o (shifter_start_o),
        .n_o             (n_o),
        .k_o             (k_o),
        .m_o             (m_o),
        .c_src_sel_o     (c_src_sel_o),
        .sp_rd_addr_o    (sp_rd_addr_o),
        .sp_wr_en_o      (sp_wr_en_o),
        .sp_wr_addr_o    (sp_wr_addr_o),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .error_o         (error_o),
        .cycles_o        (cycles_o),
        .state_dbg_o     (state_dbg_o)
    );

    // Clock and safety net.
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running required finished");
        $fatal(1, "time limit");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return {14'd0, operand_load_o, shifter_start_o, n_o, k_o, m_o, c_src_sel_o,
                sp_rd_addr_o, sp_wr_addr_o, sp_wr_en_o, busy_o, done_o, error_o} | {24'd0, cycles_o};
    endfunction

    // Runs one operation from IDLE back to IDLE, checking every phase.
    task automatic run_op(input vec_t v);
        int   bound;
        logic bad;
        @(negedge clk_i);
        chk("idle_busy", {31'd0, busy_o}, 32'd0);
        chk("idle_dims_held", {26'd0, n_o, k_o, m_o}, {26'd0, pn, pk, pm});
        chk("idle_addr_held", {28'd0, sp_rd_addr_o, sp_wr_addr_o}, {28'd0, prd, pwr});
        n_i = v.n; k_i = v.k; m_i = v.m; mode_i = v.mode;
        sp_rd_sel_i = v.rd; sp_wr_sel_i = v.wr;
        start_i = 1'b1;
        exp_q.push_back(v.exp_cycles);

        // LOAD
        @(negedge clk_i);
        start_i = 1'b0;
        chk("load_strobe", {30'd0, operand_load_o, shifter_start_o}, 32'd2);
        chk("load_busy_err", {30'd0, busy_o, error_o}, 32'd2);
        chk("load_dims", {26'd0, n_o, k_o, m_o}, {26'd0, v.n, v.k, v.m});
        chk("load_addr", {28'd0, sp_rd_addr_o, sp_wr_addr_o}, {28'd0, v.rd, v.wr});
        chk("load_csrc", {31'd0, c_src_sel_o}, {31'd0, v.mode});
        pn = v.n; pk = v.k; pm = v.m; prd = v.rd; pwr = v.wr;

        // LAUNCH
        @(negedge clk_i);
        chk("launch_strobe", {30'd0, operand_load_o, shifter_start_o}, 32'd1);
        chk("launch_csrc", {31'd0, c_src_sel_o}, {31'd0, v.mode});
        shifter_done_i = v.stale;

        // WAIT
        bound = (v.delay != 0) ? v.delay : TIMEOUT;
        bad = 1'b0;
        for (int j = 0; j < bound; j++) begin
            @(negedge clk_i);
            if (sp_wr_en_o || done_o || operand_load_o || shifter_start_o || !busy_o)
                bad = 1'b1;
            shifter_done_i = (v.delay != 0) && (j == v.delay - 1);
            start_i = v.poke && (j == 1);
        end
        chk("wait_quiet", {31'd0, bad}, 32'd0);
        start_i = 1'b0;

        if (v.delay != 0) begin
            // STORE
            @(negedge clk_i);
            shifter_done_i = 1'b0;
            chk("store_wr_en", {31'd0, sp_wr_en_o}, 32'd1);
            chk("store_addr", {28'd0, sp_rd_addr_o, sp_wr_addr_o}, {28'd0, v.rd, v.wr});
            chk("store_csrc_done", {30'd0, c_src_sel_o, done_o}, {30'd0, v.mode, 1'b0});
        end

        // DONE or ERR
        @(negedge clk_i);
        shifter_done_i = 1'b0;
        chk("fin_done_busy", {29'd0, done_o, busy_o, sp_wr_en_o}, 32'd6);
        chk("fin_csrc", {31'd0, c_src_sel_o}, 32'd0);
        chk("fin_cycles", {24'd0, cycles_o}, {24'd0, exp_q.pop_front()});
        chk("fin_error", {31'd0, error_o}, {31'd0, v.exp_err});
        if (v.poke) begin
            start_i = 1'b1;
            n_i = ~v.n; k_i = ~v.k; m_i = ~v.m; sp_wr_sel_i = ~v.wr;
        end

        // Back in IDLE
        @(negedge clk_i);
        start_i = 1'b0;
        chk("post_idle", {29'd0, done_o, busy_o, operand_load_o}, 32'd0);
        chk("post_error_sticky", {31'd0, error_o}, {31'd0, v.exp_err});
        chk("post_cycles_hold", {24'd0, cycles_o}, {24'd0, v.exp_cycles});
        @(negedge clk_i);
        chk("no_relaunch", {30'd0, operand_load_o, busy_o}, 32'd0);
    endtask

    initial begin
        logic bad;
        //           n     k     m     md    rd    wr    dly stl   poke  cyc    err
        vecs[0] = '{2'd0, 2'd0, 2'd2, 1'b0, 2'd0, 2'd2, 9,  1'b0, 1'b0, 8'd9,  1'b0};
        vecs[1] = '{2'd1, 2'd2, 2'd0, 1'b0, 2'd3, 2'd0, 0,  1'b0, 1'b0, 8'd32, 1'b1};
        vecs[2] = '{2'd3, 2'd3, 2'd3, 1'b1, 2'd1, 2'd1, 12, 1'b0, 1'b0, 8'd12, 1'b0};
        vecs[3] = '{2'd0, 2'd2, 2'd1, 1'b0, 2'd2, 2'd3, 5,  1'b1, 1'b1, 8'd5,  1'b0};
        vecs[4] = '{2'd2, 2'd1, 2'd3, 1'b1, 2'd0, 2'd0, 1,  1'b1, 1'b0, 8'd1,  1'b0};
        vecs[5] = '{2'd1, 2'd0, 2'd2, 1'b1, 2'd3, 2'd1, 32, 1'b0, 1'b0, 8'd32, 1'b0};

        rst_i = 1'b1; start_i = 1'b0; n_i = '0; k_i = '0; m_i = '0; mode_i = 1'b0;
        sp_rd_sel_i = '0; sp_wr_sel_i = '0; shifter_done_i = 1'b0;
        pn = '0; pk = '0; pm = '0; prd = '0; pwr = '0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        chk("reset_outputs", all_outs(), 32'd0);

        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i]);
        end

        // Reset in the middle of WAIT aborts without a write or done.
        @(negedge clk_i);
        n_i = 2'd2; k_i = 2'd2; m_i = 2'd2; mode_i = 1'b1;
        sp_rd_sel_i = 2'd3; sp_wr_sel_i = 2'd2; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (5) @(negedge clk_i);
        chk("pre_reset_busy", {31'd0, busy_o}, 32'd1);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        chk("midwait_reset_outputs", all_outs(), 32'd0);
        chk("midwait_reset_cycles", {24'd0, cycles_o}, 32'd0);
        bad = 1'b0;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk_i);
            if (sp_wr_en_o || done_o || busy_o) bad = 1'b1;
        end
        chk("post_reset_quiet", {31'd0, bad}, 32'd0);
        pn = '0; pk = '0; pm = '0; prd = '0; pwr = '0;
        run_op(vecs[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
